// File: rtl/bus_arb.sv
// Round-robin arbiter sharing the CPU-side system bus between num_masters requesters.
// One transaction is in flight at a time. A bus-timeout guard ends any transaction whose
// slave never acks: it returns zero data to the master and flags the error.
module bus_arb #(
  parameter int unsigned num_masters    = 2,
  parameter int unsigned timeout_cycles = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [num_masters-1:0]      m_stb,
  input  logic [num_masters-1:0]      m_we,
  input  logic [num_masters*22-1:0]   m_addr,
  input  logic [num_masters*32-1:0]   m_dout,
  output logic [31:0]                 m_din,
  output logic [num_masters-1:0]      m_ack,
  output logic                        s_stb,
  output logic                        s_we,
  output logic [21:0]                 s_addr,
  output logic [31:0]                 s_dout,
  input  logic [31:0]                 s_din,
  input  logic                        s_ack,
  output logic [num_masters-1:0]      grant,
  output logic                        err,
  output logic [21:0]                 err_addr,
  output logic [7:0]                  err_cnt
);

  localparam int unsigned AW       = 22;
  localparam int unsigned DW       = 32;
  localparam int unsigned IDX_W    = (num_masters > 1) ? $clog2(num_masters) : 1;
  localparam int unsigned CNT_W    = (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  localparam bit          TO_EN    = (timeout_cycles != 0);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(timeout_cycles - 1);
  localparam logic [7:0]  CNT_SAT  = 8'd255;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_TOUT = 2'd2
  } state_e;

  state_e                 state_q;
  logic [num_masters-1:0] grant_q;
  logic [IDX_W-1:0]       last_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic [AW-1:0]          err_addr_q;
  logic [7:0]             err_cnt_q;
  logic [7:0]             err_cnt_d;

  logic                   pick_found;
  logic [IDX_W-1:0]       pick_idx;
  logic [IDX_W-1:0]       cand_idx;
  logic [num_masters-1:0] pick_oh;

  logic                   gnt_we;
  logic [AW-1:0]          gnt_addr;
  logic [DW-1:0]          gnt_dout;
  logic                   tout_hit;

  // Round-robin pick: first requester searching upward from the one after the last owner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_q;
    cand_idx   = last_q;
    pick_oh    = '0;
    for (int unsigned i = 1; i <= num_masters; i++) begin
      cand_idx = IDX_W'((32'(last_q) + i) % num_masters);
      if (!pick_found && m_stb[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
    pick_oh[pick_idx] = 1'b1;
  end

  // Request fields of the current owner; last_q always holds the owner while a grant is live.
  always_comb begin
    gnt_we   = m_we[last_q];
    gnt_addr = m_addr[32'(last_q) * AW +: AW];
    gnt_dout = m_dout[32'(last_q) * DW +: DW];
  end

  // Timeout terminal count, bump of the BUSY counter and saturating error count.
  always_comb begin
    tout_hit  = TO_EN && (cnt_q == CNT_TERM);
    cnt_d     = TO_EN ? cnt_q + CNT_W'(1) : cnt_q;
    err_cnt_d = (err_cnt_q == CNT_SAT) ? err_cnt_q : err_cnt_q + 8'd1;
  end

  // Arbiter FSM with grant, owner pointer, timeout counter and error bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      last_q     <= IDX_W'(num_masters - 1);
      cnt_q      <= '0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pick_found) begin
            grant_q <= pick_oh;
            last_q  <= pick_idx;
            cnt_q   <= '0;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          // An ack landing on the terminal cycle still completes normally.
          if (s_ack) begin
            grant_q <= '0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else if (tout_hit) begin
            state_q <= S_TOUT;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_TOUT: begin
          err_addr_q <= gnt_addr;
          err_cnt_q  <= err_cnt_d;
          grant_q    <= '0;
          cnt_q      <= '0;
          state_q    <= S_IDLE;
        end
        default: begin
          grant_q <= '0;
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Bus-side and master-side decode; acks pass through in the same cycle as s_ack.
  always_comb begin
    s_stb  = 1'b0;
    s_we   = 1'b0;
    s_addr = '0;
    s_dout = '0;
    m_ack  = '0;
    m_din  = '0;
    err    = 1'b0;
    unique case (state_q)
      S_BUSY: begin
        s_stb  = 1'b1;
        s_we   = gnt_we;
        s_addr = gnt_addr;
        s_dout = gnt_dout;
        if (s_ack) begin
          m_ack = grant_q;
          m_din = s_din;
        end
      end
      S_TOUT: begin
        m_ack = grant_q;
        err   = 1'b1;
      end
      default: ;
    endcase
  end

  assign grant    = grant_q;
  assign err_addr = err_addr_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_bus_arb.sv
// Bench for bus_arb: vector table of single transactions plus hand sequences for
// alternation, stray acks, mid-transaction request drop, async reset and error saturation.
module tb_bus_arb;

  localparam int unsigned NM = 2;
  localparam int unsigned TO = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NM-1:0]     m_stb;
  logic [NM-1:0]     m_we;
  logic [NM*22-1:0]  m_addr;
  logic [NM*32-1:0]  m_dout;
  logic [31:0]       m_din;
  logic [NM-1:0]     m_ack;
  logic              s_stb;
  logic              s_we;
  logic [21:0]       s_addr;
  logic [31:0]       s_dout;
  logic [31:0]       s_din;
  logic              s_ack;
  logic [NM-1:0]     grant;
  logic              err;
  logic [21:0]       err_addr;
  logic [7:0]        err_cnt;

  bus_arb #(.num_masters(NM), .timeout_cycles(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr), .m_dout(m_dout),
    .m_din(m_din), .m_ack(m_ack),
    .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr), .s_dout(s_dout),
    .s_din(s_din), .s_ack(s_ack),
    .grant(grant), .err(err), .err_addr(err_addr), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned m;
    logic        we;
    logic [21:0] addr;
    logic [31:0] dout;
    int          lat;      // BUSY cycle on which the slave acks; 0 = never
    logic [31:0] sdin;
    logic [31:0] exp_din;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [NM-1:0] ack;
    logic [31:0]   din;
    logic          err;
    logic          stb;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_err_cnt  = 8'd0;
  logic [21:0] exp_err_addr = 22'd0;

  // Slave model state
  int          busy_n     = 0;
  int          slave_lat  = 0;
  logic [31:0] slave_data = 32'd0;
  logic        stray_ack  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave: acks on BUSY cycle slave_lat; stray_ack injects an ack while no strobe is up.
  always @(posedge clk) begin
    #1;
    if (!rst_n || !s_stb) begin
      busy_n = 0;
      s_ack  = stray_ack;
      s_din  = stray_ack ? slave_data : 32'd0;
    end else begin
      busy_n++;
      s_ack = (slave_lat != 0) && (busy_n == slave_lat);
      s_din = s_ack ? slave_data : 32'd0;
    end
  end

  // Scoreboard monitor: every m_ack pulse consumes one expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ack_onehot", 64'($onehot0(m_ack)), 64'd1);
      if (m_ack != '0) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_ack", 64'(m_ack), 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("m_ack", 64'(m_ack), 64'(mon_e.ack));
          chk("m_din", 64'(m_din), 64'(mon_e.din));
          chk("err_at_ack", 64'(err), 64'(mon_e.err));
          chk("s_stb_at_ack", 64'(s_stb), 64'(mon_e.stb));
          chk("grant_at_ack", 64'(grant), 64'(mon_e.ack));
        end
      end else begin
        chk("noack_din", 64'(m_din), 64'd0);
        chk("noack_err", 64'(err), 64'd0);
      end
    end
  end

  task automatic push_exp(input int unsigned m, input logic [31:0] din, input logic e_err);
    exp_t e;
    e.ack = NM'(1) << m;
    e.din = din;
    e.err = e_err;
    e.stb = !e_err;
    sb_q.push_back(e);
  endtask

  task automatic wait_acks(input int n, input int have, input string name);
    int got;
    int cyc;
    got = have;
    cyc = 0;
    while (got < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (m_ack != '0) got++;
    end
    chk({name, "_acks_seen"}, 64'(got), 64'(n));
  endtask

  task automatic run_vec(input vec_t v, input string name);
    logic [NM-1:0] oh;
    oh = NM'(1) << v.m;
    @(posedge clk); #1;
    m_we[v.m]             = v.we;
    m_addr[v.m*22 +: 22]  = v.addr;
    m_dout[v.m*32 +: 32]  = v.dout;
    m_stb[v.m]            = 1'b1;
    slave_lat             = v.lat;
    slave_data            = v.sdin;
    push_exp(v.m, v.exp_din, v.exp_err);
    if (v.exp_err) begin
      exp_err_addr = v.addr;
      if (exp_err_cnt != 8'd255) exp_err_cnt = exp_err_cnt + 8'd1;
    end
    @(negedge clk);
    chk({name, "_idle_s_stb"}, 64'(s_stb), 64'd0);
    chk({name, "_idle_grant"}, 64'(grant), 64'd0);
    @(negedge clk);
    chk({name, "_busy_s_stb"}, 64'(s_stb), 64'd1);
    chk({name, "_busy_grant"}, 64'(grant), 64'(oh));
    chk({name, "_s_addr"}, 64'(s_addr), 64'(v.addr));
    chk({name, "_s_we"}, 64'(s_we), 64'(v.we));
    chk({name, "_s_dout"}, 64'(s_dout), 64'(v.dout));
    wait_acks(1, (m_ack != '0) ? 1 : 0, name);
    @(posedge clk); #1;
    m_stb[v.m] = 1'b0;
    slave_lat  = 0;
    @(negedge clk);
    chk({name, "_err_cnt"}, 64'(err_cnt), 64'(exp_err_cnt));
    chk({name, "_err_addr"}, 64'(err_addr), 64'(exp_err_addr));
    chk({name, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    vec_t v;

    tbl[0] = '{m:0, we:1'b0, addr:22'h000100, dout:32'h0,         lat:3,  sdin:32'hDEADBEEF, exp_din:32'hDEADBEEF, exp_err:1'b0};
    tbl[1] = '{m:1, we:1'b1, addr:22'h3FFFC0, dout:32'h12345678,  lat:0,  sdin:32'h0,        exp_din:32'h0,        exp_err:1'b1};
    tbl[2] = '{m:0, we:1'b1, addr:22'h2AAAAA, dout:32'h87654321,  lat:16, sdin:32'hCAFEF00D, exp_din:32'hCAFEF00D, exp_err:1'b0};
    tbl[3] = '{m:1, we:1'b0, addr:22'h155555, dout:32'h0,         lat:1,  sdin:32'h0BADF00D, exp_din:32'h0BADF00D, exp_err:1'b0};
    tbl[4] = '{m:0, we:1'b0, addr:22'h000000, dout:32'h0,         lat:17, sdin:32'h11111111, exp_din:32'h0,        exp_err:1'b1};
    tbl[5] = '{m:1, we:1'b0, addr:22'h3FFFFF, dout:32'h0,         lat:2,  sdin:32'hFFFFFFFF, exp_din:32'hFFFFFFFF, exp_err:1'b0};

    rst_n  = 1'b0;
    m_stb  = '0;
    m_we   = '0;
    m_addr = '0;
    m_dout = '0;
    s_ack  = 1'b0;
    s_din  = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_s_stb", 64'(s_stb), 64'd0);
    chk("rst_m_ack", 64'(m_ack), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_err_addr", 64'(err_addr), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_m_din", 64'(m_din), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single-transaction vectors: read, timeout, ack on terminal cycle, late ack, etc.
    for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Two masters requesting continuously alternate, starting after last owner (master 1).
    @(posedge clk); #1;
    m_addr[0 +: 22]  = 22'h000011;
    m_addr[22 +: 22] = 22'h000022;
    m_we             = '0;
    slave_lat        = 1;
    slave_data       = 32'hA5A50000;
    push_exp(0, 32'hA5A50000, 1'b0);
    push_exp(1, 32'hA5A50000, 1'b0);
    push_exp(0, 32'hA5A50000, 1'b0);
    push_exp(1, 32'hA5A50000, 1'b0);
    m_stb = 2'b11;
    wait_acks(4, 0, "alt");
    @(posedge clk); #1;
    m_stb     = '0;
    slave_lat = 0;
    @(negedge clk);
    chk("alt_sb_empty", 64'(sb_q.size()), 64'd0);

    // Stray ack while idle is ignored.
    @(negedge clk);
    stray_ack  = 1'b1;
    slave_data = 32'h00000055;
    @(negedge clk);
    chk("stray_m_ack", 64'(m_ack), 64'd0);
    chk("stray_m_din", 64'(m_din), 64'd0);
    chk("stray_s_stb", 64'(s_stb), 64'd0);
    stray_ack = 1'b0;
    @(negedge clk);
    chk("stray_grant", 64'(grant), 64'd0);

    // Requester drops m_stb mid-BUSY: transaction still completes with its ack.
    @(posedge clk); #1;
    m_addr[0 +: 22] = 22'h000444;
    slave_lat       = 3;
    slave_data      = 32'h13579BDF;
    push_exp(0, 32'h13579BDF, 1'b0);
    m_stb[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("drop_busy_s_stb", 64'(s_stb), 64'd1);
    @(posedge clk); #1;
    m_stb[0] = 1'b0;
    wait_acks(1, 0, "drop");
    @(posedge clk); #1;
    slave_lat = 0;
    @(negedge clk);
    chk("drop_sb_empty", 64'(sb_q.size()), 64'd0);

    // Async reset mid-BUSY of master 0, then master 0 must still win first after release.
    @(posedge clk); #1;
    m_addr[0 +: 22] = 22'h000777;
    slave_lat       = 0;
    m_stb           = 2'b01;
    repeat (3) @(negedge clk);
    chk("prerst_s_stb", 64'(s_stb), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_s_stb", 64'(s_stb), 64'd0);
    chk("midrst_m_ack", 64'(m_ack), 64'd0);
    chk("midrst_grant", 64'(grant), 64'd0);
    chk("midrst_err_cnt", 64'(err_cnt), 64'd0);
    exp_err_cnt  = 8'd0;
    exp_err_addr = 22'd0;
    m_stb        = 2'b11;
    slave_lat    = 1;
    slave_data   = 32'h0F0F0F0F;
    push_exp(0, 32'h0F0F0F0F, 1'b0);
    push_exp(1, 32'h0F0F0F0F, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_acks(2, 0, "postrst");
    @(posedge clk); #1;
    m_stb     = '0;
    slave_lat = 0;
    @(negedge clk);
    chk("postrst_sb_empty", 64'(sb_q.size()), 64'd0);

    // 257 timeouts: error count saturates at 255 while err keeps pulsing.
    for (int i = 0; i < 257; i++) begin
      v = '{m:1, we:1'b1, addr:22'(i * 4093), dout:32'(i), lat:0, sdin:32'h0, exp_din:32'h0, exp_err:1'b1};
      run_vec(v, "sat");
    end
    chk("sat_err_cnt_final", 64'(err_cnt), 64'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
